// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel synchronizer and debounce FSM producing level, press and release
module button_conditioner #(
   parameter int N         = 4,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] btn_raw,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release
);

   localparam int            CW      = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      HIGH,
      WAIT_LOW
   } state_t;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_ch
         logic          s1;
         logic          s2;
         state_t        state;
         logic [CW-1:0] cnt;
         logic          level_q;
         logic          press_q;
         logic          release_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s1        <= 1'b0;
               s2        <= 1'b0;
               state     <= IDLE_LOW;
               cnt       <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               s1        <= btn_raw[i];
               s2        <= s1;
               press_q   <= 1'b0;
               release_q <= 1'b0;
               case (state)
                  IDLE_LOW: begin
                     if (s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                     end
                  end
                  WAIT_HIGH: begin
                     // Any low sample restarts qualification from scratch.
                     if (!s2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                     end else if (cnt == CNT_MAX) begin
                        state   <= HIGH;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  HIGH: begin
                     if (!s2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                     end
                  end
                  WAIT_LOW: begin
                     if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                     end else if (cnt == CNT_MAX) begin
                        state     <= IDLE_LOW;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  default: begin
                     state <= IDLE_LOW;
                     cnt   <= '0;
                  end
               endcase
            end
         end

         assign btn_level[i]   = level_q;
         assign btn_press[i]   = press_q;
         assign btn_release[i] = release_q;
      end
   endgenerate

endmodule
